// File: rtl/trace_debugger_defines.sv
// Shared trace-debugger encodings: packet formats, header field positions and
// payload lengths used by both the encoder checks and the packet decoder.
package trace_debugger_defines;

  typedef enum logic [1:0] {
    TRDB_BF   = 2'd0,
    TRDB_BD   = 2'd1,
    TRDB_ADDR = 2'd2,
    TRDB_SYNC = 2'd3
  } trdb_format_t;

  typedef enum logic [1:0] {
    TRDB_SF_START     = 2'd0,
    TRDB_SF_EXCEPTION = 2'd1,
    TRDB_SF_CONTEXT   = 2'd2
  } trdb_subformat_t;

  typedef enum logic [1:0] {
    DEC_IDLE,
    DEC_PAYLOAD,
    DEC_EMIT
  } trdb_dec_state_t;

  // Header bit positions
  localparam int unsigned HDR_FMT_LSB   = 0;
  localparam int unsigned HDR_SUB_LSB   = 2;
  localparam int unsigned HDR_BCNT_LSB  = 4;
  localparam int unsigned HDR_BCNT_W    = 5;
  localparam int unsigned HDR_PRIV_LSB  = 9;
  localparam int unsigned HDR_PRIV_W    = 3;
  localparam int unsigned HDR_INT_BIT   = 12;
  localparam int unsigned HDR_CAUSE_LSB = 13;
  localparam int unsigned HDR_CAUSE_W   = 5;
  localparam int unsigned HDR_RSVD_LSB  = 18;

  // Branch map lives in bits [30:0] of its payload word
  localparam int unsigned BMAP_W = 31;

  // Payload words following the header
  localparam logic [1:0] PLEN_BF         = 2'd2;
  localparam logic [1:0] PLEN_BD         = 2'd2;
  localparam logic [1:0] PLEN_ADDR       = 2'd1;
  localparam logic [1:0] PLEN_SYNC_START = 2'd1;
  localparam logic [1:0] PLEN_SYNC_EXC   = 2'd2;
  localparam logic [1:0] PLEN_SYNC_CTX   = 2'd0;

endpackage

// File: rtl/trdb_packet_length.sv
// Combinational header classifier: payload word count and malformed flag.
module trdb_packet_length
  import trace_debugger_defines::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] header_i,
  output logic [1:0]      len_o,
  output logic            malformed_o
);

  trdb_format_t fmt;
  logic [1:0]   sub;
  logic         rsvd_set;
  logic         unused_fields;

  assign fmt           = trdb_format_t'(header_i[HDR_FMT_LSB +: 2]);
  assign sub           = header_i[HDR_SUB_LSB +: 2];
  assign rsvd_set      = |header_i[XLEN-1:HDR_RSVD_LSB];
  // Branch/priv/cause fields do not influence the length
  assign unused_fields = ^header_i[HDR_RSVD_LSB-1:HDR_BCNT_LSB];

  // Look up payload length and reject illegal format/subformat pairs
  always_comb begin
    len_o       = '0;
    malformed_o = rsvd_set;
    unique case (fmt)
      TRDB_BF: begin
        len_o = PLEN_BF;
        if (sub != 2'd0) malformed_o = 1'b1;
      end
      TRDB_BD: begin
        len_o = PLEN_BD;
        if (sub != 2'd0) malformed_o = 1'b1;
      end
      TRDB_ADDR: begin
        len_o = PLEN_ADDR;
        if (sub != 2'd0) malformed_o = 1'b1;
      end
      TRDB_SYNC: begin
        unique case (sub)
          2'd0:    len_o = PLEN_SYNC_START;
          2'd1:    len_o = PLEN_SYNC_EXC;
          2'd2:    len_o = PLEN_SYNC_CTX;
          default: malformed_o = 1'b1;
        endcase
      end
      default: malformed_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/trdb_packet_decoder.sv
// Trace packet decoder: collects header + payload words into one record per
// packet and resolves branch-differential addresses against the last address.
module trdb_packet_decoder
  import trace_debugger_defines::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned PRIVLEN  = 3,
  parameter int unsigned CAUSELEN = 5
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic [XLEN-1:0]     data_i,
  input  logic                valid_i,
  output logic                ready_o,
  output logic                packet_valid_o,
  input  logic                packet_ready_i,
  output trdb_format_t        format_o,
  output trdb_subformat_t     subformat_o,
  output logic [4:0]          branch_cnt_o,
  output logic [30:0]         branch_map_o,
  output logic [XLEN-1:0]     addr_o,
  output logic [XLEN-1:0]     tval_o,
  output logic [PRIVLEN-1:0]  priv_o,
  output logic                interrupt_o,
  output logic [CAUSELEN-1:0] cause_o,
  output logic                error_o
);

  trdb_dec_state_t         state_q, state_d;
  logic [1:0]              cnt_q, cnt_d;
  logic                    idx_q, idx_d;
  logic [HDR_RSVD_LSB-1:0] hdr_q, hdr_d;
  logic [XLEN-1:0]         w0_q, w0_d;
  logic [XLEN-1:0]         w1_q, w1_d;
  logic [XLEN-1:0]         last_addr_q, last_addr_d;
  logic                    error_q, error_d;

  logic [1:0]      hdr_len;
  logic            hdr_bad;
  logic            word_xfer;
  trdb_format_t    hdr_fmt;
  trdb_subformat_t hdr_sub;
  logic [XLEN-1:0] rec_addr;
  logic            rec_has_addr;

  trdb_packet_length #(
    .XLEN(XLEN)
  ) i_packet_length (
    .header_i    (data_i),
    .len_o       (hdr_len),
    .malformed_o (hdr_bad)
  );

  assign word_xfer = valid_i && ready_o;
  assign hdr_fmt   = trdb_format_t'(hdr_q[HDR_FMT_LSB +: 2]);
  assign hdr_sub   = trdb_subformat_t'(hdr_q[HDR_SUB_LSB +: 2]);

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= DEC_IDLE;
      cnt_q       <= '0;
      idx_q       <= 1'b0;
      hdr_q       <= '0;
      w0_q        <= '0;
      w1_q        <= '0;
      last_addr_q <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      hdr_q       <= hdr_d;
      w0_q        <= w0_d;
      w1_q        <= w1_d;
      last_addr_q <= last_addr_d;
      error_q     <= error_d;
    end
  end

  // Next-state: header capture, payload collection, record handshake, flush
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    hdr_d       = hdr_q;
    w0_d        = w0_q;
    w1_d        = w1_q;
    last_addr_d = last_addr_q;
    error_d     = 1'b0;
    unique case (state_q)
      DEC_IDLE: begin
        if (word_xfer) begin
          if (hdr_bad) begin
            error_d = 1'b1;
          end else begin
            hdr_d   = data_i[HDR_RSVD_LSB-1:0];
            cnt_d   = hdr_len;
            idx_d   = 1'b0;
            w0_d    = '0;
            w1_d    = '0;
            state_d = (hdr_len == 2'd0) ? DEC_EMIT : DEC_PAYLOAD;
          end
        end
      end
      DEC_PAYLOAD: begin
        if (word_xfer) begin
          if (!idx_q) w0_d = data_i;
          else        w1_d = data_i;
          idx_d = 1'b1;
          cnt_d = cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_d = DEC_EMIT;
        end
      end
      DEC_EMIT: begin
        if (packet_ready_i) begin
          state_d = DEC_IDLE;
          if (rec_has_addr) last_addr_d = rec_addr;
        end
      end
      default: state_d = DEC_IDLE;
    endcase
    if (flush_i) begin
      state_d     = DEC_IDLE;
      cnt_d       = '0;
      idx_d       = 1'b0;
      last_addr_d = '0;
      error_d     = 1'b0;
    end
  end

  // Outputs: record fields are only driven while the record is presented
  always_comb begin
    rec_addr       = '0;
    rec_has_addr   = 1'b0;
    ready_o        = (state_q != DEC_EMIT);
    packet_valid_o = (state_q == DEC_EMIT);
    error_o        = error_q;
    format_o       = TRDB_BF;
    subformat_o    = TRDB_SF_START;
    branch_cnt_o   = '0;
    branch_map_o   = '0;
    addr_o         = '0;
    tval_o         = '0;
    priv_o         = '0;
    interrupt_o    = 1'b0;
    cause_o        = '0;
    unique case (hdr_fmt)
      TRDB_BF: begin
        rec_addr     = w1_q;
        rec_has_addr = 1'b1;
      end
      TRDB_BD: begin
        rec_addr     = last_addr_q + w1_q;
        rec_has_addr = 1'b1;
      end
      TRDB_ADDR: begin
        rec_addr     = w0_q;
        rec_has_addr = 1'b1;
      end
      TRDB_SYNC: begin
        if (hdr_sub != TRDB_SF_CONTEXT) begin
          rec_addr     = w0_q;
          rec_has_addr = 1'b1;
        end
      end
      default: ;
    endcase
    if (state_q == DEC_EMIT) begin
      format_o = hdr_fmt;
      addr_o   = rec_addr;
      if (hdr_fmt == TRDB_BF || hdr_fmt == TRDB_BD) begin
        branch_cnt_o = hdr_q[HDR_BCNT_LSB +: HDR_BCNT_W];
        branch_map_o = w0_q[BMAP_W-1:0];
      end
      if (hdr_fmt == TRDB_SYNC) begin
        subformat_o = hdr_sub;
        priv_o      = PRIVLEN'(hdr_q[HDR_PRIV_LSB +: HDR_PRIV_W]);
        if (hdr_sub == TRDB_SF_EXCEPTION) begin
          interrupt_o = hdr_q[HDR_INT_BIT];
          cause_o     = CAUSELEN'(hdr_q[HDR_CAUSE_LSB +: HDR_CAUSE_W]);
          tval_o      = w1_q;
        end
      end
    end
  end

endmodule

// File: doc/trdb_packet_decoder.md
# trdb_packet_decoder

Receive-side counterpart of the trace encoder: consumes the packet word stream that the trace debugger emits and reconstructs one decoded packet record per packet. Branch-differential addresses are resolved to absolute addresses. Sits between the trace sink (FIFO/DMA readback) and the on-chip trace checker or host bridge. Used for self-checking and closed-loop verification of the encoder.

## Interface
Parameters:
- XLEN, 32, word and address width; only 32 and 64 are legal.
- PRIVLEN, 3, privilege field width.
- CAUSELEN, 5, exception cause width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; one clock, asynchronous and active-low.
- flush_i  in  1  synchronous abort to IDLE; also clears the last-address register.
- data_i  in  XLEN  packet word.
- valid_i  in  1  data_i valid.
- ready_o  out  1  decoder accepts data_i.
- packet_valid_o  out  1  decoded record valid.
- packet_ready_i  in  1  consumer accepts record.
- format_o  out  trdb_format_t  packet format.
- subformat_o  out  trdb_subformat_t  sync subformat.
- branch_cnt_o  out  5  number of valid branch-map bits.
- branch_map_o  out  31  branch map; bit 0 is the oldest branch.
- addr_o  out  XLEN  absolute address.
- tval_o  out  XLEN  trap value (SYNC exception only).
- priv_o  out  PRIVLEN  privilege.
- interrupt_o  out  1  interrupt flag.
- cause_o  out  CAUSELEN  exception cause.
- error_o  out  1  one-cycle pulse on a malformed header.

## Operation
- Header word layout:
  - [1:0] format: 0 BF, 1 BD, 2 ADDR, 3 SYNC.
  - [3:2] subformat: 0 START, 1 EXCEPTION, 2 CONTEXT.
  - [8:4] branch count, 0..31.
  - [11:9] priv.
  - [12] interrupt.
  - [17:13] cause.
  - [XLEN-1:18] reserved, must be 0.
- Payload words following the header:
  - BF: branch map, then absolute address (2 words).
  - BD: branch map, then signed address difference (2 words).
  - ADDR: absolute address (1 word).
  - SYNC START: address (1 word).
  - SYNC EXCEPTION: address, then tval (2 words).
  - SYNC CONTEXT: none (0 words).
- The branch-map word carries the map in bits [30:0]; bit 31 is ignored.
- BD: addr_o = last_addr + diff, modulo 2^XLEN (wraps silently).
- last_addr updates on every emitted record that carries an address, including the BD-resolved value.
- Malformed header: reserved bits nonzero, SYNC with subformat 3, or a non-SYNC header with subformat != 0.
  - Pulse error_o, drop the word, stay in IDLE.
- Fields that a format does not carry are driven as 0.
- FSM:
  - IDLE: ready_o=1. On a valid header: latch header fields, load the word counter with the payload length, go to PAYLOAD. If the length is 0, go directly to EMIT.
  - PAYLOAD: ready_o=1. Each accepted word is stored per the index and the counter decrements. When the last word is accepted, go to EMIT.
  - EMIT: ready_o=0, packet_valid_o=1. All outputs stay stable until packet_ready_i; then go to IDLE.

## Timing
- Reset values:
  - All outputs 0, except ready_o=1 (IDLE).
  - last_addr=0.
- A word transfers when valid_i && ready_o.
- A record transfers when packet_valid_o && packet_ready_i.
- Latency: packet_valid_o rises the cycle after the last word of a packet is accepted.
- Throughput: a packet of N payload words occupies at least N+2 cycles; no overlap between EMIT and the next header.
- packet_valid_o never drops without a handshake, except on flush_i or reset.
- flush_i has priority over everything. Next cycle: IDLE, packet_valid_o=0, last_addr=0, any partial packet discarded, no error_o.
- Reset asserted mid-packet: outputs return to reset values asynchronously.
- valid_i may deassert between payload words; the FSM holds state.

## Structure
- The shared package trace_debugger_defines holds:
  - trdb_format_t and trdb_subformat_t encodings.
  - Header bit-position constants.
  - Payload-length constants per format/subformat.
- Sub-module trdb_packet_length: combinational header → {payload length, malformed flag}. Kept separate so the encoder-side assertions can reuse it.

## Test plan
- BF header (cnt=3, priv=3), map 0x5, addr 0x1000 → record format=BF, branch_cnt=3, branch_map=0x5, addr=0x1000; last_addr=0x1000.
- Follow with a BD packet with diff 0xFFFFFFF0 → addr_o=0x0FF0. Then last_addr=0xFFFFFFF8 and diff 0x10 → addr_o=0x8 (wrap).
- SYNC EXCEPTION (cause=2, interrupt=1), addr 0x80, tval 0xDEAD → all fields correct, packet_valid_o the cycle after the tval word. SYNC CONTEXT goes directly to EMIT.
- Hold packet_ready_i=0 for 5 cycles → outputs stable, ready_o=0 throughout; a new header is accepted the cycle after the handshake.
- Header with bit 20 set → error_o for 1 cycle, no record, next valid header decodes normally.
- flush_i after the BF map word → IDLE, no record, next BD resolves against last_addr=0.
